// File: rtl/trans_tx_fetch_ipa.sv
// Two-lane TCDM read fetcher feeding the TX data buffer.
// A command gives a base address and a beat count; each beat is one 32-bit word per lane
// (lane k of beat n reads base + 8*n + 4*k). Each lane issues, buffers and pushes on its own,
// throttled by a 2-slot credit that covers both in-flight reads and buffered words.
module trans_tx_fetch_ipa #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_req_i,
  output logic                       cmd_gnt_o,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]       cmd_len_i,
  output logic [1:0]                 tcdm_req_o,
  output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
  input  logic [1:0]                 tcdm_gnt_i,
  input  logic [1:0]                 tcdm_r_valid_i,
  input  logic [1:0][31:0]           tcdm_r_rdata_i,
  output logic [1:0][31:0]           tx_data_push_dat_o,
  output logic [1:0]                 tx_data_push_req_o,
  input  logic [1:0]                 tx_data_push_gnt_i,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                       r_state;
  logic [ADDR_WIDTH-1:0]        r_base;
  logic [LEN_WIDTH-1:0]         r_len;
  logic                         r_done;
  logic                         r_rst_dly;
  logic [1:0][LEN_WIDTH-1:0]    r_issued;
  logic [1:0]                   r_out;
  logic [1:0][1:0][31:0]        r_mem;
  logic [1:0]                   r_wptr;
  logic [1:0]                   r_rptr;
  logic [1:0][1:0]              r_occ;

  logic [1:0]                   w_req;
  logic [1:0]                   w_grant;
  logic [1:0]                   w_wr;
  logic [1:0]                   w_pop;
  logic [1:0][ADDR_WIDTH-1:0]   w_addr;
  logic                         w_all_done;

  // Per-lane request, credit and FIFO handshake decode.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_pop[k]   = (r_occ[k] != 2'd0) & tx_data_push_gnt_i[k];
      // Responses only count when a read is actually in flight on this lane.
      w_wr[k]    = tcdm_r_valid_i[k] & r_out[k];
      // A pop this cycle frees a slot in time for the response of a read granted now,
      // which keeps one beat per cycle sustainable without ever overfilling the FIFO.
      w_req[k]   = (r_state == StRun) && (r_issued[k] != r_len) &&
                   (({1'b0, r_occ[k]} + {2'b00, r_out[k]} - {2'b00, w_pop[k]}) < 3'd2);
      w_grant[k] = w_req[k] & tcdm_gnt_i[k];
      w_addr[k]  = r_base + (ADDR_WIDTH'(r_issued[k]) << 3) + ADDR_WIDTH'(4 * k);
    end
  end

  assign w_all_done = (r_issued[0] == r_len) && (r_issued[1] == r_len) && (r_out == 2'b00) &&
                      (r_occ[0] == 2'd0) && (r_occ[1] == 2'd0);

  // Output drive; address and data read as zero whenever they are not meaningful.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      tcdm_req_o[k]         = w_req[k];
      tcdm_add_o[k]         = w_req[k] ? w_addr[k] : '0;
      tx_data_push_req_o[k] = (r_occ[k] != 2'd0);
      tx_data_push_dat_o[k] = (r_occ[k] != 2'd0) ? r_mem[k][r_rptr[k]] : 32'd0;
    end
  end

  assign cmd_gnt_o = (r_state == StIdle);
  assign busy_o    = (r_state == StRun);
  assign done_o    = r_done;

  // Command FSM: latch the command, finish when every beat has been pushed out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (cmd_req_i) begin
            if (cmd_len_i != '0) begin
              r_base  <= cmd_addr_i & ~ADDR_WIDTH'(7);
              r_len   <= cmd_len_i;
              r_state <= StRun;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_all_done) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Per-lane issue counters, in-flight flags and FIFO pointers/occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_issued <= '0;
      r_out    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_occ    <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_state == StIdle) begin
          r_issued[k] <= '0;
        end else if (w_grant[k]) begin
          r_issued[k] <= r_issued[k] + LEN_WIDTH'(1);
        end
        // Response lands exactly one cycle after the grant.
        r_out[k] <= w_grant[k];
        if (w_wr[k]) begin
          r_wptr[k] <= ~r_wptr[k];
        end
        if (w_pop[k]) begin
          r_rptr[k] <= ~r_rptr[k];
        end
        case ({w_wr[k], w_pop[k]})
          2'b10:   r_occ[k] <= r_occ[k] + 2'd1;
          2'b01:   r_occ[k] <= r_occ[k] - 2'd1;
          default: r_occ[k] <= r_occ[k];
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care while the matching occupancy is zero.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (w_wr[k]) begin
        r_mem[k][r_wptr[k]] <= tcdm_r_rdata_i[k];
      end
    end
  end

  // Tracks the cycle after reset, when a response to a pre-reset grant may still arrive.
  always_ff @(posedge clk_i) begin
    r_rst_dly <= rst_i;
  end

  ap_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i || r_rst_dly)
    ((tcdm_r_valid_i & ~r_out) == 2'b00));

endmodule

// File: tb/tb_trans_tx_fetch_ipa.sv
// Bench for trans_tx_fetch_ipa: directed vector table, a reset-during-run sequence and
// randomized commands, all scored against an address/data model of the fetch.
module tb_trans_tx_fetch_ipa;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_req_i;
  logic              cmd_gnt_o;
  logic [31:0]       cmd_addr_i;
  logic [15:0]       cmd_len_i;
  logic [1:0]        tcdm_req_o;
  logic [1:0][31:0]  tcdm_add_o;
  logic [1:0]        tcdm_gnt_i;
  logic [1:0]        tcdm_r_valid_i;
  logic [1:0][31:0]  tcdm_r_rdata_i;
  logic [1:0][31:0]  tx_data_push_dat_o;
  logic [1:0]        tx_data_push_req_o;
  logic [1:0]        tx_data_push_gnt_i;
  logic              busy_o;
  logic              done_o;

  always #5 clk_i = ~clk_i;

  trans_tx_fetch_ipa #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cmd_req_i          (cmd_req_i),
    .cmd_gnt_o          (cmd_gnt_o),
    .cmd_addr_i         (cmd_addr_i),
    .cmd_len_i          (cmd_len_i),
    .tcdm_req_o         (tcdm_req_o),
    .tcdm_add_o         (tcdm_add_o),
    .tcdm_gnt_i         (tcdm_gnt_i),
    .tcdm_r_valid_i     (tcdm_r_valid_i),
    .tcdm_r_rdata_i     (tcdm_r_rdata_i),
    .tx_data_push_dat_o (tx_data_push_dat_o),
    .tx_data_push_req_o (tx_data_push_req_o),
    .tx_data_push_gnt_i (tx_data_push_gnt_i),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed traffic per lane.
  logic [31:0] iss_log  [2][64];
  logic [31:0] push_log [2][64];
  int          iss_n    [2];
  int          push_n   [2];
  int          first_push_cyc [2];
  int          last_push_cyc  [2];
  int          max_pend [2];
  int          done_cnt;
  int          done_cyc;
  int          acc_cyc;
  bit          busy_seen;
  logic [1:0]  prev_req;
  logic [1:0]  prev_gnt;
  logic [31:0] prev_addr [2];
  logic        prev_rst;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          tg;
    int          pg;
    int          stall1;
    logic [31:0] e0_first;
    logic [31:0] e0_last;
    logic [31:0] e1_first;
    logic [31:0] e1_last;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic pick(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    for (int k = 0; k < 2; k++) begin
      iss_n[k] = 0;
      push_n[k] = 0;
      first_push_cyc[k] = -1;
      last_push_cyc[k] = -1;
      max_pend[k] = 0;
    end
    done_cnt  = 0;
    done_cyc  = -1;
    acc_cyc   = -1;
    busy_seen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_gnt"}, 64'(cmd_gnt_o), 64'd1);
    check({tag, "_tcdm_req"}, 64'(tcdm_req_o), 64'd0);
    check({tag, "_push_req"}, 64'(tx_data_push_req_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_tcdm_add"}, 64'(tcdm_add_o), 64'd0);
    check({tag, "_push_dat"}, 64'(tx_data_push_dat_o), 64'd0);
  endtask

  // TCDM responder: data one cycle after each grant.
  always @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      tcdm_r_valid_i[k] <= tcdm_req_o[k] & tcdm_gnt_i[k];
      tcdm_r_rdata_i[k] <= mem_rd(tcdm_add_o[k]);
    end
  end

  always @(posedge clk_i) cyc++;

  // Monitor on the falling edge: log handshakes, check request hold while ungranted.
  always @(negedge clk_i) begin
    if (cmd_req_i && cmd_gnt_o && !rst_i) acc_cyc = cyc + 1;
    if (busy_o) busy_seen = 1'b1;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst_i && !prev_rst && prev_req[k] && !prev_gnt[k])
        check("req_hold", {31'd0, tcdm_req_o[k], tcdm_add_o[k]}, {31'd0, 1'b1, prev_addr[k]});
      if (tcdm_req_o[k] && tcdm_gnt_i[k]) begin
        if (iss_n[k] < 64) iss_log[k][iss_n[k]] = tcdm_add_o[k];
        iss_n[k]++;
      end
      if (tx_data_push_req_o[k] && tx_data_push_gnt_i[k]) begin
        if (push_n[k] < 64) push_log[k][push_n[k]] = tx_data_push_dat_o[k];
        push_n[k]++;
        if (first_push_cyc[k] < 0) first_push_cyc[k] = cyc;
        last_push_cyc[k] = cyc;
      end
      if (iss_n[k] - push_n[k] > max_pend[k]) max_pend[k] = iss_n[k] - push_n[k];
      prev_req[k]  = tcdm_req_o[k];
      prev_gnt[k]  = tcdm_gnt_i[k];
      prev_addr[k] = tcdm_add_o[k];
    end
    prev_rst = rst_i;
  end

  // Issue one command, drive random grants until done, then score against the model.
  task automatic run_cmd(input logic [31:0] addr, input int len, input int tg, input int pg,
                         input int stall1);
    logic [31:0] base;
    logic [31:0] exp_a;
    int          n;
    for (n = 0; n < 100 && !cmd_gnt_o; n++) begin
      @(posedge clk_i); #1;
    end
    check("cmd_gnt_idle", 64'(cmd_gnt_o), 64'd1);
    clear_log();
    cmd_req_i  = 1'b1;
    cmd_addr_i = addr;
    cmd_len_i  = 16'(len);
    tcdm_gnt_i = 2'b00;
    tx_data_push_gnt_i = 2'b00;
    @(posedge clk_i); #1;
    cmd_req_i = 1'b0;
    for (n = 0; n < 3000 && done_cnt == 0; n++) begin
      tcdm_gnt_i[0] = pick(tg);
      tcdm_gnt_i[1] = pick(tg);
      tx_data_push_gnt_i[0] = pick(pg);
      tx_data_push_gnt_i[1] = (n < stall1) ? 1'b0 : pick(pg);
      @(posedge clk_i); #1;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) begin
      tcdm_gnt_i = {pick(tg), pick(tg)};
      tx_data_push_gnt_i = {pick(pg), pick(pg)};
      @(posedge clk_i); #1;
    end
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_after", 64'(busy_o), 64'd0);
    base = addr & 32'hFFFF_FFF8;
    for (int k = 0; k < 2; k++) begin
      check("iss_count", 64'(iss_n[k]), 64'(len));
      check("push_count", 64'(push_n[k]), 64'(len));
      check("pend_bound", 64'(max_pend[k] <= 2), 64'd1);
      for (int b = 0; b < len && b < 64; b++) begin
        exp_a = base + 32'(8 * b) + 32'(4 * k);
        if (b < iss_n[k]) check("iss_addr", 64'(iss_log[k][b]), 64'(exp_a));
        if (b < push_n[k]) check("push_data", 64'(push_log[k][b]), 64'(mem_rd(exp_a)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 4, 100, 100, 0,
                32'h0000_1000, 32'h0000_1018, 32'h0000_1004, 32'h0000_101C};
    vecs[1] = '{32'hFFFF_FFF8, 2, 100, 100, 0,
                32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004};
    vecs[2] = '{32'h1000_0005, 3, 100, 100, 0,
                32'h1000_0000, 32'h1000_0010, 32'h1000_0004, 32'h1000_0014};
    vecs[3] = '{32'h0000_2000, 8, 100, 100, 10,
                32'h0000_2000, 32'h0000_2038, 32'h0000_2004, 32'h0000_203C};
    vecs[4] = '{32'h0000_0040, 1, 50, 50, 0,
                32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044};
    vecs[5] = '{32'h0000_3000, 0, 100, 100, 0, 32'd0, 32'd0, 32'd0, 32'd0};

    rst_i = 1'b1;
    cmd_req_i = 1'b0;
    cmd_addr_i = '0;
    cmd_len_i = '0;
    tcdm_gnt_i = 2'b00;
    tx_data_push_gnt_i = 2'b00;
    prev_rst = 1'b1;
    prev_req = 2'b00;
    prev_gnt = 2'b00;
    clear_log();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_reset_outputs("rst");

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].addr, vecs[i].len, vecs[i].tg, vecs[i].pg, vecs[i].stall1);
      if (vecs[i].len > 0 && iss_n[0] == vecs[i].len && iss_n[1] == vecs[i].len) begin
        check("l0_first", 64'(iss_log[0][0]), 64'(vecs[i].e0_first));
        check("l0_last", 64'(iss_log[0][vecs[i].len-1]), 64'(vecs[i].e0_last));
        check("l1_first", 64'(iss_log[1][0]), 64'(vecs[i].e1_first));
        check("l1_last", 64'(iss_log[1][vecs[i].len-1]), 64'(vecs[i].e1_last));
      end
      if (vecs[i].tg == 100 && vecs[i].pg == 100 && vecs[i].stall1 == 0 && vecs[i].len > 0) begin
        for (int k = 0; k < 2; k++) begin
          check("first_push_lat", 64'(first_push_cyc[k]), 64'(acc_cyc + 2));
          check("last_push_lat", 64'(last_push_cyc[k]), 64'(acc_cyc + 1 + vecs[i].len));
        end
      end
      if (vecs[i].len == 0) begin
        check("len0_done_cyc", 64'(done_cyc), 64'(acc_cyc));
        check("len0_busy", 64'(busy_seen), 64'd0);
      end
      if (vecs[i].stall1 > 0) begin
        check("stall_pend", 64'(max_pend[1]), 64'd2);
        check("lane0_first", 64'(last_push_cyc[0] < first_push_cyc[1]), 64'd1);
      end
    end

    // Reset in the middle of a run with beats still pending.
    clear_log();
    @(posedge clk_i); #1;
    cmd_req_i = 1'b1;
    cmd_addr_i = 32'h0000_5000;
    cmd_len_i = 16'd8;
    tcdm_gnt_i = 2'b11;
    tx_data_push_gnt_i = 2'b11;
    @(posedge clk_i); #1;
    cmd_req_i = 1'b0;
    for (int n = 0; n < 50 && iss_n[0] < 5; n++) begin
      @(posedge clk_i); #1;
    end
    check("pre_reset_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_reset_outputs("midrst");
    clear_log();
    repeat (5) @(posedge clk_i);
    #1;
    check("midrst_no_push", 64'(push_n[0] + push_n[1]), 64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_no_busy", 64'(busy_seen), 64'd0);
    run_cmd(32'h0000_6000, 3, 100, 100, 0);

    // Randomized commands.
    for (int r = 0; r < 24; r++) begin
      run_cmd($urandom, int'($urandom_range(12, 0)), int'($urandom_range(100, 30)),
              int'($urandom_range(100, 30)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
